// File: rtl/w8_twiddle_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : w8_twiddle_stage_pkg
//  Description : Shared definitions for the W8 twiddle rotation stage:
//                default widths, the 3-bit twiddle index type, the named
//                indices K0..K7 and the shift amounts that realise the
//                constant c = 0.6875 = 2^-1 + 2^-3 + 2^-4.
//  Revision    : 1.0  initial release
// ============================================================================
package w8_twiddle_stage_pkg;

    localparam int W8_DATA_WIDTH = 20;
    localparam int W8_FRAC       = 16;

    typedef logic [2:0] twk_t;

    localparam twk_t K0 = 3'd0;
    localparam twk_t K1 = 3'd1;
    localparam twk_t K2 = 3'd2;
    localparam twk_t K3 = 3'd3;
    localparam twk_t K4 = 3'd4;
    localparam twk_t K5 = 3'd5;
    localparam twk_t K6 = 3'd6;
    localparam twk_t K7 = 3'd7;

    // c = 1/2 + 1/8 + 1/16
    localparam int C_SH_A = 1;
    localparam int C_SH_B = 3;
    localparam int C_SH_C = 4;

endpackage
`default_nettype wire

// File: rtl/w8_const_mul.sv
`default_nettype none
// ============================================================================
//  Module      : w8_const_mul
//  Description : Combinational multiply by c = 0.6875 using three arithmetic
//                right shifts (each truncating toward -inf) summed with
//                wrap-around modulo 2^DATA_WIDTH.
//  Ports       : i_x  signed input sample
//                o_y  c * i_x
//  Revision    : 1.0  initial release
// ============================================================================
module w8_const_mul
    import w8_twiddle_stage_pkg::*;
#(
    parameter int DATA_WIDTH = W8_DATA_WIDTH
)(
    input  logic [DATA_WIDTH-1:0] i_x,
    output logic [DATA_WIDTH-1:0] o_y
);

    logic signed [DATA_WIDTH-1:0] w_xs;

    assign w_xs = i_x;
    assign o_y  = (w_xs >>> C_SH_A) + (w_xs >>> C_SH_B) + (w_xs >>> C_SH_C);

endmodule
`default_nettype wire

// File: rtl/w8_twiddle_stage.sv
`default_nettype none
// ============================================================================
//  Module      : w8_twiddle_stage
//  Description : Streaming rotation of complex samples by W8^k, k being a
//                per-frame sample index. Two registered stages (S1 captures
//                the sample and k, S2 holds the rotated result) with
//                valid/ready backpressure, 1 sample/cycle, latency 2.
//  Ports       : i_clk, i_rst_n (async, active-low)
//                i_valid/o_ready, i_frame_start, i_re, i_im   - input side
//                o_valid/i_ready, o_re, o_im, o_k, o_last      - output side
//  Config      : EXACT_NEG_EN - when defined, negation is exact two's
//                complement (~x + 1); otherwise ones' complement (~x).
//  Revision    : 1.0  initial release
// ============================================================================
module w8_twiddle_stage
    import w8_twiddle_stage_pkg::*;
#(
    parameter int DATA_WIDTH = W8_DATA_WIDTH,
    parameter int FRAC       = W8_FRAC
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_frame_start,
    input  logic [DATA_WIDTH-1:0] i_re,
    input  logic [DATA_WIDTH-1:0] i_im,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_re,
    output logic [DATA_WIDTH-1:0] o_im,
    output logic [2:0]            o_k,
    output logic                  o_last
);

    // The fixed-point format must leave at least one integer bit.
    if (FRAC <= 0 || FRAC >= DATA_WIDTH) begin : g_frac_check
        $error("w8_twiddle_stage: FRAC must be in 1..DATA_WIDTH-1");
    end

    localparam logic [DATA_WIDTH-1:0] C_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [DATA_WIDTH-1:0] neg(input logic [DATA_WIDTH-1:0] x);
`ifdef EXACT_NEG_EN
        return ~x + C_ONE;
`else
        return ~x;
`endif
    endfunction

    // Stage 1
    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    twk_t                  r_k;
    twk_t                  r_k_cnt;

    // Stage 2
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_re;
    logic [DATA_WIDTH-1:0] r_im;
    twk_t                  r_ok;
    logic                  r_last;

    logic                  w_s2_adv;
    logic                  w_accept;
    twk_t                  w_k_used;
    logic [DATA_WIDTH-1:0] w_ca;
    logic [DATA_WIDTH-1:0] w_cb;
    logic [DATA_WIDTH-1:0] w_rot_re;
    logic [DATA_WIDTH-1:0] w_rot_im;

    // S2 moves whenever it is empty or its sample leaves; S1 follows it,
    // so o_ready sees i_ready combinationally and no bubble is inserted.
    assign w_s2_adv = !r_s2_valid || i_ready;
    assign o_ready  = !r_s1_valid || w_s2_adv;
    assign w_accept = i_valid && o_ready;
    assign w_k_used = i_frame_start ? K0 : r_k_cnt;

    w8_const_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul_a (.i_x(r_a), .o_y(w_ca));
    w8_const_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul_b (.i_x(r_b), .o_y(w_cb));

    always_comb begin
        w_rot_re = r_a;
        w_rot_im = r_b;
        case (r_k)
            K0: begin w_rot_re = r_a;                 w_rot_im = r_b;                 end
            K1: begin w_rot_re = w_ca + w_cb;         w_rot_im = w_cb + neg(w_ca);    end
            K2: begin w_rot_re = r_b;                 w_rot_im = neg(r_a);            end
            K3: begin w_rot_re = w_cb + neg(w_ca);    w_rot_im = neg(w_ca) + neg(w_cb); end
            K4: begin w_rot_re = neg(r_a);            w_rot_im = neg(r_b);            end
            K5: begin w_rot_re = neg(w_ca) + neg(w_cb); w_rot_im = w_ca + neg(w_cb);  end
            K6: begin w_rot_re = neg(r_b);            w_rot_im = r_a;                 end
            K7: begin w_rot_re = w_ca + neg(w_cb);    w_rot_im = w_ca + w_cb;         end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_k        <= K0;
            r_k_cnt    <= K0;
        end else begin
            if (o_ready) begin
                r_s1_valid <= i_valid;
            end
            if (w_accept) begin
                r_a     <= i_re;
                r_b     <= i_im;
                r_k     <= w_k_used;
                r_k_cnt <= w_k_used + 3'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_valid <= 1'b0;
            r_re       <= '0;
            r_im       <= '0;
            r_ok       <= K0;
            r_last     <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_re   <= w_rot_re;
                r_im   <= w_rot_im;
                r_ok   <= r_k;
                r_last <= (r_k == K7);
            end
        end
    end

    assign o_valid = r_s2_valid;
    assign o_re    = r_re;
    assign o_im    = r_im;
    assign o_k     = r_ok;
    assign o_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_w8_twiddle_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_w8_twiddle_stage
//  Description : Self-checking bench for w8_twiddle_stage. An integer-domain
//                reference model predicts every output in accept order;
//                directed scenarios add literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_w8_twiddle_stage;

    localparam int DW = 20;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [2:0]    k;
        logic          last;
    } out_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic          fs;
    logic [DW-1:0] re_in;
    logic [DW-1:0] im_in;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_re;
    logic [DW-1:0] o_im;
    logic [2:0]    o_k;
    logic          o_last;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   mdl_k  = 0;
    out_t exp_q[$];
    out_t log_q[$];
    logic prev_hold = 1'b0;
    logic [3*DW:0] held;
    logic saw_block = 1'b0;

    always #5 clk = ~clk;

    w8_twiddle_stage dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_frame_start (fs),
        .i_re          (re_in),
        .i_im          (im_in),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_re          (o_re),
        .o_im          (o_im),
        .o_k           (o_k),
        .o_last        (o_last)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- reference model (plain integer arithmetic) ----------
    function automatic int sx(input logic [DW-1:0] v);
        int r;
        r = int'(v);
        if (v[DW-1]) r = r - (1 << DW);
        return r;
    endfunction

    function automatic int fdiv(input int x, input int d);
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic int cmul(input int x);
        return fdiv(x, 2) + fdiv(x, 8) + fdiv(x, 16);
    endfunction

    function automatic int ng(input int x);
`ifdef EXACT_NEG_EN
        return -x;
`else
        return -x - 1;
`endif
    endfunction

    function automatic logic [DW-1:0] wrap(input int v);
        int m;
        m = v & ((1 << DW) - 1);
        return m[DW-1:0];
    endfunction

    function automatic out_t rot(input logic [DW-1:0] re, input logic [DW-1:0] im, input int k);
        out_t o;
        int a, b, ca, cb, r, i;
        a = sx(re); b = sx(im); ca = cmul(a); cb = cmul(b);
        case (k)
            0: begin r = a;               i = b;               end
            1: begin r = ca + cb;         i = cb + ng(ca);     end
            2: begin r = b;               i = ng(a);           end
            3: begin r = cb + ng(ca);     i = ng(ca) + ng(cb); end
            4: begin r = ng(a);           i = ng(b);           end
            5: begin r = ng(ca) + ng(cb); i = ca + ng(cb);     end
            6: begin r = ng(b);           i = a;               end
            default: begin r = ca + ng(cb); i = ca + cb;       end
        endcase
        o.re = wrap(r); o.im = wrap(i); o.k = 3'(k); o.last = (k == 7);
        return o;
    endfunction

    // ---------------- compare process -------------------------------------
    always @(negedge clk) begin
        out_t e, g;
        int kk;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (o_valid && prev_hold)
                chk("hold_stable", 64'({o_re, o_im, o_k, o_last}), 64'(held));
            if (o_valid && i_ready) begin
                g.re = o_re; g.im = o_im; g.k = o_k; g.last = o_last;
                log_q.push_back(g);
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("output", 64'({g.re, g.im, g.k, g.last}), 64'({e.re, e.im, e.k, e.last}));
                end
            end
            prev_hold = o_valid && !i_ready;
            held      = {o_re, o_im, o_k, o_last};
            if (i_valid && !o_ready) saw_block = 1'b1;
            if (i_valid && o_ready) begin
                kk    = fs ? 0 : mdl_k;
                mdl_k = (kk + 1) % 8;
                exp_q.push_back(rot(re_in, im_in, kk));
            end
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] m, input logic f);
        int n;
        n = 0;
        i_valid = 1'b1; re_in = r; im_in = m; fs = f;
        forever begin
            @(negedge clk);
            if (o_ready) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 64'(1), 64'(0));
                break;
            end
        end
        @(posedge clk); #1;
        i_valid = 1'b0; fs = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- directed scenarios ----------------------------------
    initial begin
        logic [20:0] kseq;
        int nlast;
        rst_n = 1'b0; i_valid = 1'b0; fs = 1'b0; re_in = '0; im_in = '0; i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_o_valid", 64'(o_valid), 64'(0));
        chk("reset_o_ready", 64'(o_ready), 64'(1));
        chk("reset_outputs", 64'({o_re, o_im, o_k, o_last}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single sample, k=0, latency check
        log_q.delete();
        send(20'h10000, 20'h0, 1'b1);
        chk("lat_not_yet", 64'(o_valid), 64'(0));
        @(posedge clk); #1;
        chk("lat_2_valid", 64'(o_valid), 64'(1));
        drain();
        chk("first_out", 64'({log_q[0].re, log_q[0].im, log_q[0].k, log_q[0].last}),
            64'({20'h10000, 20'h00000, 3'd0, 1'b0}));

        // full frame of (1.0, 0)
        log_q.delete();
        for (int i = 0; i < 8; i++) send(20'h10000, 20'h0, i == 0);
        drain();
        chk("frame_count", 64'(log_q.size()), 64'(8));
`ifdef EXACT_NEG_EN
        chk("k1", 64'({log_q[1].re, log_q[1].im}), 64'({20'h0B000, 20'hF5000}));
        chk("k2", 64'({log_q[2].re, log_q[2].im}), 64'({20'h00000, 20'hF0000}));
        chk("k6", 64'({log_q[6].re, log_q[6].im}), 64'({20'h00000, 20'h10000}));
`else
        chk("k1", 64'({log_q[1].re, log_q[1].im}), 64'({20'h0B000, 20'hF4FFF}));
        chk("k2", 64'({log_q[2].re, log_q[2].im}), 64'({20'h00000, 20'hEFFFF}));
        chk("k6", 64'({log_q[6].re, log_q[6].im}), 64'({20'hFFFFF, 20'h10000}));
`endif
        nlast = 0;
        foreach (log_q[i]) if (log_q[i].last) nlast++;
        chk("last_count", 64'(nlast), 64'(1));
        chk("last_on_8th", 64'(log_q[7].last), 64'(1));

        // backpressure: continuous stream with a 5-cycle downstream stall
        log_q.delete();
        saw_block = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(20'(32'h01357 * (i + 1)), 20'(32'hFE9A3 - 32'h0A111 * i), i == 0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 i_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        drain();
        chk("stall_o_ready_dropped", 64'(saw_block), 64'(1));
        chk("stall_count", 64'(log_q.size()), 64'(10));

        // frame_start on the 4th sample restarts k
        log_q.delete();
        for (int i = 0; i < 7; i++) send(20'h0C000, 20'h34000, (i == 0) || (i == 3));
        drain();
        kseq = '0;
        foreach (log_q[i]) kseq = {kseq[17:0], log_q[i].k};
        chk("restart_kseq", 64'(kseq), 64'({3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3}));

        // wrap-around of ca + cb at k=1 with most-negative inputs
        log_q.delete();
        send(20'h0, 20'h0, 1'b1);
        send(20'h80000, 20'h80000, 1'b0);
        drain();
`ifdef EXACT_NEG_EN
        chk("wrap_k1", 64'({log_q[1].re, log_q[1].im, log_q[1].k}), 64'({20'h50000, 20'h00000, 3'd1}));
`else
        chk("wrap_k1", 64'({log_q[1].re, log_q[1].im, log_q[1].k}), 64'({20'h50000, 20'hFFFFF, 3'd1}));
`endif

        // asynchronous reset with two samples in flight
        i_ready = 1'b0;
        send(20'h11111, 20'h22222, 1'b1);
        send(20'h33333, 20'h44444, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_o_valid", 64'(o_valid), 64'(0));
        exp_q.delete();
        mdl_k = 0;
        @(posedge clk); #1;
        rst_n = 1'b1; i_ready = 1'b1;
        log_q.delete();
        send(20'h01234, 20'h04321, 1'b0);
        send(20'h05678, 20'h08765, 1'b0);
        drain();
        chk("post_rst_k0", 64'(log_q[0].k), 64'(0));
        chk("post_rst_k1", 64'(log_q[1].k), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
